// File: rtl/rr_arb_mux.sv
// rr_arb_mux
// Round-robin arbiter and registered multiplexer for CHANNELS valid/ready
// input streams feeding one shared consumer. Multi-beat packets lock the
// arbiter to their channel until the final beat, so packets never interleave.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset
//   in_valid   per-channel beat valid
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last    per-channel end-of-packet marker
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  output register holds a beat
//   out_data   registered beat data
//   out_last   registered end-of-packet marker
//   out_sel    index of the channel that sourced the current output beat
//   out_ready  consumer takes the beat when out_valid && out_ready
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_BITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_BITS-1:0]       out_sel,
  input  logic                      out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } arbStateT;

  arbStateT            state_q, state_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [SEL_BITS-1:0] lockCh_q, lockCh_d;
  logic                outValid_q, outValid_d;
  logic [WIDTH-1:0]    outData_q, outData_d;
  logic                outLast_q, outLast_d;
  logic [SEL_BITS-1:0] outSel_q, outSel_d;

  logic                loadEn;
  logic                grantValid;
  logic [SEL_BITS-1:0] grant;
  logic [WIDTH-1:0]    grantData;
  logic                grantLast;
  logic                accept;
  logic [SEL_BITS-1:0] nextPtr;

  // The single-entry output register can take a new beat whenever it is
  // empty or is being drained this same cycle.
  assign loadEn = !outValid_q || out_ready;
  assign accept = !reset && loadEn && grantValid;

  // Packet end moves the round-robin pointer just past the winner.
  assign nextPtr = (grant == SEL_BITS'(CHANNELS - 1)) ? '0 : grant + SEL_BITS'(1);

  // Grant selection. While a packet is open only its own channel may win.
  // Otherwise every valid channel is ranked by its distance from the pointer
  // (wrapping modulo CHANNELS) and the closest one wins, which works for
  // channel counts that are not powers of two.
  always_comb begin
    int off;
    int bestOff;
    off        = 0;
    bestOff    = CHANNELS;
    grantValid = 1'b0;
    grant      = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (lockCh_q == SEL_BITS'(i) && in_valid[i]) begin
          grantValid = 1'b1;
          grant      = SEL_BITS'(i);
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        off = i - int'(ptr_q);
        if (off < 0) begin
          off = off + CHANNELS;
        end
        if (in_valid[i] && off < bestOff) begin
          bestOff    = off;
          grantValid = 1'b1;
          grant      = SEL_BITS'(i);
        end
      end
    end
  end

  // Data and last-flag multiplexer driven by the grant index.
  always_comb begin
    grantData = '0;
    grantLast = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_BITS'(i)) begin
        grantData = in_data[i*WIDTH +: WIDTH];
        grantLast = in_last[i];
      end
    end
  end

  // Only the granted channel sees ready, and only when the output register
  // can load; reset forces every ready low so nothing is taken mid-reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !reset && loadEn && grantValid && (grant == SEL_BITS'(i));
    end
  end

  // Next-state logic. An accepted beat with last=0 opens (or continues) a
  // packet on that channel; last=1 closes it and advances the pointer.
  // When the register loads without an accept it simply empties, leaving the
  // previous data, last and select visible but invalid.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lockCh_d   = lockCh_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outSel_d   = outSel_q;
    if (loadEn) begin
      outValid_d = accept;
    end
    if (accept) begin
      outData_d = grantData;
      outLast_d = grantLast;
      outSel_d  = grant;
      if (grantLast) begin
        state_d = IDLE;
        ptr_d   = nextPtr;
      end else begin
        state_d  = LOCKED;
        lockCh_d = grant;
      end
    end
  end

  // Arbiter state and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lockCh_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outSel_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lockCh_q   <= lockCh_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outSel_q   <= outSel_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_sel   = outSel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux
// Directed bench for rr_arb_mux: an 8-channel 32-bit instance for reset,
// round-robin, packet lock, backpressure and sparse requests, plus a
// 3-channel 16-bit instance for the non-power-of-two parameter set.
module tb_rr_arb_mux;

  logic         clock;
  logic         reset;

  logic [7:0]   inValid;
  logic [255:0] inData;
  logic [7:0]   inLast;
  logic [7:0]   inReady;
  logic         outValid;
  logic [31:0]  outData;
  logic         outLast;
  logic [2:0]   outSel;
  logic         outReady;

  logic [2:0]   inValid3;
  logic [47:0]  inData3;
  logic [2:0]   inLast3;
  logic [2:0]   inReady3;
  logic         outValid3;
  logic [15:0]  outData3;
  logic         outLast3;
  logic [1:0]   outSel3;
  logic         outReady3;

  int errors;
  int checks;

  rr_arb_mux #(.WIDTH(32), .CHANNELS(8), .SEL_BITS(3)) dut (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_data(inData), .in_last(inLast), .in_ready(inReady),
    .out_valid(outValid), .out_data(outData), .out_last(outLast), .out_sel(outSel),
    .out_ready(outReady)
  );

  rr_arb_mux #(.WIDTH(16), .CHANNELS(3), .SEL_BITS(2)) dut3 (
    .clock(clock), .reset(reset),
    .in_valid(inValid3), .in_data(inData3), .in_last(inLast3), .in_ready(inReady3),
    .out_valid(outValid3), .out_data(outData3), .out_last(outLast3), .out_sel(outSel3),
    .out_ready(outReady3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset;
    @(negedge clock);
    reset = 1'b1;
    inValid = '0; inLast = '0; outReady = 1'b1;
    inValid3 = '0; inLast3 = '0; outReady3 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    outReady = 1'b1; outReady3 = 1'b1;
    inValid = '1; inLast = '1;
    for (int i = 0; i < 8; i++) inData[i*32 +: 32] = 32'hA0 + i;
    inValid3 = '1; inLast3 = '1;
    for (int i = 0; i < 3; i++) inData3[i*16 +: 16] = 16'h10 + 16'(i);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (inReady !== 8'h00) begin errors++; $display("[TB] FAIL reset_ready c=%0d got=%h exp=00", c, inReady); end
      checks++;
      if (inReady3 !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready3 c=%0d got=%b exp=000", c, inReady3); end
      @(posedge clock); #1;
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid c=%0d got=%b exp=0", c, outValid); end
      checks++;
      if (outValid3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid3 c=%0d got=%b exp=0", c, outValid3); end
      @(negedge clock);
    end
    checks++;
    if (outData !== 32'h0 || outSel !== 3'd0 || outLast !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outregs got data=%h sel=%0d last=%b exp 0/0/0", outData, outSel, outLast);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (inReady !== 8'h01) begin errors++; $display("[TB] FAIL first_grant_ready got=%h exp=01", inReady); end
    checks++;
    if (inReady3 !== 3'b001) begin errors++; $display("[TB] FAIL first_grant_ready3 got=%b exp=001", inReady3); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd0 || outData !== 32'hA0) begin
      errors++; $display("[TB] FAIL first_grant_out got v=%b sel=%0d data=%h exp v=1 sel=0 data=a0", outValid, outSel, outData);
    end
    @(negedge clock);
    inValid = '0; inValid3 = '0;
  endtask

  task automatic test_round_robin;
    logic [2:0] expSel;
    doReset();
    inValid = 8'hFF; inLast = 8'hFF;
    for (int i = 0; i < 8; i++) inData[i*32 +: 32] = 32'hA0 + i;
    for (int k = 0; k < 10; k++) begin
      expSel = 3'(k % 8);
      #1;
      checks++;
      if (inReady !== (8'h01 << expSel)) begin errors++; $display("[TB] FAIL rr_ready k=%0d got=%h exp=%h", k, inReady, 8'h01 << expSel); end
      @(posedge clock); #1;
      checks++;
      if (outValid !== 1'b1 || outSel !== expSel) begin
        errors++; $display("[TB] FAIL rr_sel k=%0d got v=%b sel=%0d exp v=1 sel=%0d", k, outValid, outSel, expSel);
      end
      checks++;
      if (outData !== 32'hA0 + 32'(expSel)) begin
        errors++; $display("[TB] FAIL rr_data k=%0d got=%h exp=%h", k, outData, 32'hA0 + 32'(expSel));
      end
      @(negedge clock);
    end
    inValid = '0;
  endtask

  task automatic test_packet_lock;
    doReset();
    inValid = 8'h0C; inLast = 8'h08;
    inData[2*32 +: 32] = 32'h200; inData[3*32 +: 32] = 32'h300;
    #1;
    checks++;
    if (inReady !== 8'h04) begin errors++; $display("[TB] FAIL lock_ready_b1 got=%h exp=04", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd2 || outData !== 32'h200 || outLast !== 1'b0) begin
      errors++; $display("[TB] FAIL lock_beat1 got v=%b sel=%0d data=%h last=%b exp 1/2/200/0", outValid, outSel, outData, outLast);
    end
    @(negedge clock);
    inValid = 8'h08;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++;
      if (inReady !== 8'h00) begin errors++; $display("[TB] FAIL lock_bubble_ready b=%0d got=%h exp=00", b, inReady); end
      @(posedge clock); #1;
      checks++;
      if (outValid !== 1'b0 || outSel !== 3'd2) begin
        errors++; $display("[TB] FAIL lock_bubble_out b=%0d got v=%b sel=%0d exp v=0 sel=2", b, outValid, outSel);
      end
      @(negedge clock);
    end
    inValid = 8'h0C; inData[2*32 +: 32] = 32'h201;
    #1;
    checks++;
    if (inReady !== 8'h04) begin errors++; $display("[TB] FAIL lock_ready_b2 got=%h exp=04", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd2 || outData !== 32'h201 || outLast !== 1'b0) begin
      errors++; $display("[TB] FAIL lock_beat2 got v=%b sel=%0d data=%h last=%b exp 1/2/201/0", outValid, outSel, outData, outLast);
    end
    @(negedge clock);
    inData[2*32 +: 32] = 32'h202; inLast = 8'h0C;
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd2 || outData !== 32'h202 || outLast !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_beat3 got v=%b sel=%0d data=%h last=%b exp 1/2/202/1", outValid, outSel, outData, outLast);
    end
    @(negedge clock);
    inValid = 8'h08;
    #1;
    checks++;
    if (inReady !== 8'h08) begin errors++; $display("[TB] FAIL lock_release_ready got=%h exp=08", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd3 || outData !== 32'h300 || outLast !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_next_ch got v=%b sel=%0d data=%h last=%b exp 1/3/300/1", outValid, outSel, outData, outLast);
    end
    @(negedge clock);
    inValid = '0;
  endtask

  task automatic test_backpressure;
    doReset();
    inValid = 8'h02; inLast = 8'hFF; inData[1*32 +: 32] = 32'hDEADBEEF; outReady = 1'b0;
    #1;
    checks++;
    if (inReady !== 8'h02) begin errors++; $display("[TB] FAIL bp_load_ready got=%h exp=02", inReady); end
    @(posedge clock); #1;
    @(negedge clock);
    inData[1*32 +: 32] = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (inReady !== 8'h00) begin errors++; $display("[TB] FAIL bp_ready c=%0d got=%h exp=00", c, inReady); end
      @(posedge clock); #1;
      checks++;
      if (outValid !== 1'b1 || outData !== 32'hDEADBEEF || outSel !== 3'd1) begin
        errors++; $display("[TB] FAIL bp_hold c=%0d got v=%b data=%h sel=%0d exp 1/deadbeef/1", c, outValid, outData, outSel);
      end
      @(negedge clock);
    end
    outReady = 1'b1;
    #1;
    checks++;
    if (inReady !== 8'h02) begin errors++; $display("[TB] FAIL bp_release_ready got=%h exp=02", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outData !== 32'hCAFEF00D || outSel !== 3'd1) begin
      errors++; $display("[TB] FAIL bp_next_beat got v=%b data=%h sel=%0d exp 1/cafef00d/1", outValid, outData, outSel);
    end
    @(negedge clock);
    inValid = '0;
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got v=%b exp=0", outValid); end
    @(negedge clock);
  endtask

  task automatic test_sparse;
    doReset();
    inValid = 8'h20; inLast = 8'hFF; inData[5*32 +: 32] = 32'h55;
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd5 || outData !== 32'h55) begin
      errors++; $display("[TB] FAIL sparse_first got v=%b sel=%0d data=%h exp 1/5/55", outValid, outSel, outData);
    end
    @(negedge clock);
    inData[5*32 +: 32] = 32'h56;
    #1;
    checks++;
    if (inReady !== 8'h20) begin errors++; $display("[TB] FAIL sparse_wrap_ready got=%h exp=20", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outValid !== 1'b1 || outSel !== 3'd5 || outData !== 32'h56) begin
      errors++; $display("[TB] FAIL sparse_wrap_out got v=%b sel=%0d data=%h exp 1/5/56", outValid, outSel, outData);
    end
    @(negedge clock);
    inValid = 8'h61; inData[6*32 +: 32] = 32'h66;
    #1;
    checks++;
    if (inReady !== 8'h40) begin errors++; $display("[TB] FAIL sparse_ptr6_ready got=%h exp=40", inReady); end
    @(posedge clock); #1;
    checks++;
    if (outSel !== 3'd6 || outData !== 32'h66) begin
      errors++; $display("[TB] FAIL sparse_ptr6_out got sel=%0d data=%h exp 6/66", outSel, outData);
    end
    @(negedge clock);
    inValid = '0;
  endtask

  task automatic test_param_sweep;
    logic [1:0] expSel;
    doReset();
    inValid3 = 3'b111; inLast3 = 3'b111;
    for (int i = 0; i < 3; i++) inData3[i*16 +: 16] = 16'h10 + 16'(i);
    for (int k = 0; k < 7; k++) begin
      expSel = 2'(k % 3);
      #1;
      checks++;
      if (inReady3 !== (3'b001 << expSel)) begin errors++; $display("[TB] FAIL sweep_ready k=%0d got=%b exp=%b", k, inReady3, 3'b001 << expSel); end
      @(posedge clock); #1;
      checks++;
      if (outValid3 !== 1'b1 || outSel3 !== expSel || outSel3 === 2'd3) begin
        errors++; $display("[TB] FAIL sweep_sel k=%0d got v=%b sel=%0d exp v=1 sel=%0d", k, outValid3, outSel3, expSel);
      end
      checks++;
      if (outData3 !== 16'h10 + 16'(expSel)) begin
        errors++; $display("[TB] FAIL sweep_data k=%0d got=%h exp=%h", k, outData3, 16'h10 + 16'(expSel));
      end
      @(negedge clock);
    end
    inValid3 = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    inValid = '0; inData = '0; inLast = '0; outReady = 1'b1;
    inValid3 = '0; inData3 = '0; inLast3 = '0; outReady3 = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_sparse();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit successor to the combinational 2/4/8-way 32-bit mux tree.
- Adds round-robin arbitration, valid/ready handshakes on every input and on the output, a registered output stage, and packet lock so multi-beat transfers are never interleaved.
- Sits between multiple requesters (e.g. memory/IO ports, writeback sources) and one shared consumer.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 8, number of input channels (>=2; need not be a power of two).
- SEL_BITS, 3, width of channel index; must satisfy 2^SEL_BITS >= CHANNELS.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel beat valid.
- in_data  input  CHANNELS*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  CHANNELS  per-channel end-of-packet marker (1 = single-beat or final beat).
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  SEL_BITS  index of the channel that sourced the current output beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
- Reset (sampled at clock edge while reset=1): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer=0, state=IDLE, lock channel=0. in_ready is all zeros while reset=1. Reset mid-packet discards the lock and any held beat; no beat is accepted in that cycle.
- load_en = !out_valid || out_ready. Output register is a single entry; a full register drains and refills in the same cycle, so full throughput is 1 beat per cycle.
- Grant (combinational): in IDLE, the first channel with in_valid=1 searching ptr, ptr+1, …, wrapping modulo CHANNELS. In LOCKED, only the lock channel is eligible.
- in_ready[g] = load_en && grant-exists && (g == grant). All other bits are 0. in_ready does not depend on out_ready beyond load_en.
- Accept = in_valid[g] && in_ready[g]. On accept: out_data<=in_data[g], out_last<=in_last[g], out_sel<=g, out_valid<=1. Latency is 1 cycle from input accept to out_valid.
- If load_en=1 and there is no accept, out_valid<=0; out_data, out_last, and out_sel hold their previous values.
- States:
  - IDLE -> LOCKED on an accept with in_last=0; lock channel<=g.
  - LOCKED -> IDLE on an accept from the lock channel with in_last=1.
  - IDLE stays IDLE on an accept with in_last=1.
- While LOCKED and the lock channel drops in_valid, a bubble occurs. Other valid channels are not granted and the lock is held.
- Pointer: ptr<=(g+1) mod CHANNELS only on an accept with in_last=1, i.e. at packet end. ptr is unchanged mid-packet and unchanged on idle cycles. Wrap: g=CHANNELS-1 gives ptr=0.
- Backpressure: while out_valid=1 and out_ready=0, in_ready is all zeros, and out_data, out_last, and out_sel are stable.
- No valid inputs: in_ready is all zeros and no state change occurs except out_valid clearing when drained.
- Arbitration and data muxing use a parametrised loop or tree; there are no hard-coded channel counts.

Test Plan:
- Reset: assert reset 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout. First grant after release is channel 0 (ptr=0).
- Round-robin fairness: CHANNELS=8, all in_valid=1, in_last=1, out_ready=1, in_data[i]=32'hA0+i.
  - out_sel must read 0,1,…,7,0,1 on consecutive cycles.
  - out_data must match the source channel.
  - The wrap from 7 to 0 must be observed.
- Packet lock: ch2 sends 3 beats (last on the 3rd) while ch3 is continuously valid.
  - out_sel=2 for 3 beats, then 3.
  - Drop ch2 valid for 2 cycles mid-packet -> 2 bubble cycles with out_valid=0 and in_ready[3]=0.
- Backpressure: hold out_ready=0 for 4 cycles with out_valid=1, out_data=32'hDEADBEEF -> out_data and out_sel stable, in_ready=0. On release, the next beat follows on the next cycle with no loss or duplication.
- Sparse requests: only ch5 valid, ptr=6 -> grant search wraps 6,7,0…5, granting ch5. After last, ptr=6.
- Parameter sweep: CHANNELS=3, SEL_BITS=2, WIDTH=16, all channels valid, single-beat -> out_sel cycles 0,1,2,0, and never reads 3.
